sos_sequencer: RTL

- Control sequencer for the cascaded second-order-section (SOS) IIR filter.
- Steps one shared multiply-accumulate datapath through every biquad section and every coefficient tap for each accepted input sample.
- Drives coefficient/state addresses, MAC clear/enable and delay-line write-back.
- Returns a valid/ready-handshaked completion to the sample source/sink.

---
 rtl/sos_seq_pkg.sv | 12 +
 rtl/sos_sequencer_wrap_counter.sv | 18 +
 rtl/sos_sequencer.sv | 54 +++++
 3 files changed

// File: rtl/sos_seq_pkg.sv
// sos_seq_pkg: shared state encoding, tap names and latency helper for the SOS sequencer
package sos_seq_pkg;
  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
  localparam int TAP_B0 = 0;
  localparam int TAP_B1 = 1;
  localparam int TAP_B2 = 2;
  localparam int TAP_A1 = 3;
  localparam int TAP_A2 = 4;
  function automatic int latency(input int num_sections, input int num_taps);
    return (num_taps + 1) * num_sections + 1;
  endfunction
endpackage

// File: rtl/sos_sequencer_wrap_counter.sv
// wrap_counter: up counter that wraps to zero at MAX rather than at 2**WIDTH
module wrap_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);
  assign at_max = count == WIDTH'(MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= at_max ? '0 : count + WIDTH'(1);
endmodule

// File: rtl/sos_sequencer.sv
// sos_sequencer: steps one shared MAC through every biquad section and tap per input sample
module sos_sequencer
  import sos_seq_pkg::*;
#(
  parameter  int NUM_SECTIONS = 4,
  parameter  int NUM_TAPS     = 5,
  parameter  int TAP_W        = 3,
  localparam int SEC_W        = NUM_SECTIONS > 1 ? $clog2(NUM_SECTIONS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [SEC_W-1:0] sec_idx,
  output logic [TAP_W-1:0] tap_idx,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             state_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  state_t state, state_nx;
  logic tap_max, sec_max;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = in_valid ? MAC : IDLE;
      MAC:     state_nx = flush ? IDLE : tap_max ? WB : MAC;
      WB:      state_nx = flush ? IDLE : sec_max ? DONE : MAC;
      DONE:    state_nx = (flush || out_ready) ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // tap runs only inside MAC and rests at zero elsewhere, so each section starts at b0
  wrap_counter #(.WIDTH(TAP_W), .MAX(NUM_TAPS - 1)) u_tap (
    .clk(clk), .rst_n(rst_n), .clr(flush || state != MAC), .inc(1'b1),
    .count(tap_idx), .at_max(tap_max)
  );
  wrap_counter #(.WIDTH(SEC_W), .MAX(NUM_SECTIONS - 1)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(flush || state == IDLE), .inc(state == WB),
    .count(sec_idx), .at_max(sec_max)
  );
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign mac_en    = state == MAC;
  assign mac_clr   = mac_en && tap_idx == TAP_W'(TAP_B0);
  assign state_we  = state == WB;
  assign out_valid = state == DONE;
endmodule
